// File: rtl/noc_tx_packetiser_pkg.sv
// Shared definitions for the NoC packetisers: controller state encodings and
// the counter-width helper used to size buffer pointers.
package noc_tx_packetiser_pkg;

  localparam logic [0:0] STATE_COLLECT = 1'b0;
  localparam logic [0:0] STATE_SEND    = 1'b1;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/noc_tx_packetiser_if.sv
// Core-write and router-injection signals of the transmit packetiser.
// master: the core/router environment, slave: the packetiser.
interface noc_tx_packetiser_if #(
  parameter int unsigned COORD_BITS = 1,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [COORD_BITS-1:0] x_coord_in;
  logic                  x_coord_valid;
  logic [COORD_BITS-1:0] y_coord_in;
  logic                  y_coord_valid;
  logic [DATA_WIDTH-1:0] message_in;
  logic                  message_valid;
  logic                  packet_complete;
  logic                  message_ready;
  logic [DATA_WIDTH-1:0] flit_data;
  logic [COORD_BITS-1:0] flit_x_dest;
  logic [COORD_BITS-1:0] flit_y_dest;
  logic                  flit_last;
  logic                  flit_valid;
  logic                  flit_ready;
  logic                  busy;
  logic                  drop_err;

  modport master (
    output x_coord_in, x_coord_valid, y_coord_in, y_coord_valid,
    output message_in, message_valid, packet_complete, flit_ready,
    input  message_ready, flit_data, flit_x_dest, flit_y_dest,
    input  flit_last, flit_valid, busy, drop_err
  );

  modport slave (
    input  x_coord_in, x_coord_valid, y_coord_in, y_coord_valid,
    input  message_in, message_valid, packet_complete, flit_ready,
    output message_ready, flit_data, flit_x_dest, flit_y_dest,
    output flit_last, flit_valid, busy, drop_err
  );

endinterface

// File: rtl/noc_tx_packetiser.sv
// Transmit packetiser: buffers destination and message words from the core,
// then injects them into the Hoplite router one flit per accepted handshake.
module noc_tx_packetiser
  import noc_tx_packetiser_pkg::*;
#(
  parameter int unsigned COORD_BITS       = 1,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned MAX_PACKET_WORDS = 8
) (
  input logic               clk,
  input logic               reset_n,
  noc_tx_packetiser_if.slave bus
);

  localparam int unsigned CNT_W = clog2_min1(MAX_PACKET_WORDS + 1);
  localparam int unsigned IDX_W = clog2_min1(MAX_PACKET_WORDS);
  localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(MAX_PACKET_WORDS);

  logic [0:0]            r_state, w_state_next;
  logic [CNT_W-1:0]      r_count, w_count_next;
  logic [IDX_W-1:0]      r_idx, w_idx_next;
  logic [COORD_BITS-1:0] r_x_dest, w_x_dest_next;
  logic [COORD_BITS-1:0] r_y_dest, w_y_dest_next;
  logic                  r_drop_err, w_drop_err_next;
  logic [DATA_WIDTH-1:0] r_buf [MAX_PACKET_WORDS];

  logic                  w_busy;
  logic                  w_count_full;
  logic                  w_flit_last;
  logic                  w_any_strobe;
  logic                  w_buf_we;
  logic [IDX_W-1:0]      w_wr_ptr;

  assign w_busy       = (r_state == STATE_SEND);
  assign w_count_full = (r_count == MAX_COUNT);
  assign w_wr_ptr     = r_count[IDX_W-1:0];
  assign w_flit_last  = w_busy && (CNT_W'(r_idx) == (r_count - CNT_W'(1)));
  assign w_any_strobe = bus.message_valid | bus.x_coord_valid | bus.y_coord_valid |
                        bus.packet_complete;

  always_comb begin
    w_state_next    = r_state;
    w_count_next    = r_count;
    w_idx_next      = r_idx;
    w_x_dest_next   = r_x_dest;
    w_y_dest_next   = r_y_dest;
    w_drop_err_next = r_drop_err;
    w_buf_we        = 1'b0;

    case (r_state)
      STATE_COLLECT: begin
        if (bus.x_coord_valid) w_x_dest_next = bus.x_coord_in;
        if (bus.y_coord_valid) w_y_dest_next = bus.y_coord_in;
        if (bus.message_valid) begin
          if (!w_count_full) begin
            w_buf_we     = 1'b1;
            w_count_next = r_count + CNT_W'(1);
          end else begin
            w_drop_err_next = 1'b1;
          end
        end
        // Length includes a word written in the same cycle as the strobe.
        if (bus.packet_complete && (w_count_next != '0)) begin
          w_idx_next   = '0;
          w_state_next = STATE_SEND;
        end
      end
      STATE_SEND: begin
        if (w_any_strobe) w_drop_err_next = 1'b1;
        if (bus.flit_ready) begin
          if (w_flit_last) begin
            w_count_next = '0;
            w_idx_next   = '0;
            w_state_next = STATE_COLLECT;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end
      end
      default: w_state_next = STATE_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= STATE_COLLECT;
      r_count    <= '0;
      r_idx      <= '0;
      r_x_dest   <= '0;
      r_y_dest   <= '0;
      r_drop_err <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_idx      <= w_idx_next;
      r_x_dest   <= w_x_dest_next;
      r_y_dest   <= w_y_dest_next;
      r_drop_err <= w_drop_err_next;
    end
  end

  // Payload storage needs no reset; the output is gated while idle.
  always_ff @(posedge clk) begin
    if (w_buf_we) r_buf[w_wr_ptr] <= bus.message_in;
  end

  assign bus.message_ready = !w_busy && !w_count_full;
  assign bus.busy          = w_busy;
  assign bus.flit_valid    = w_busy;
  assign bus.flit_last     = w_flit_last;
  assign bus.flit_data     = w_busy ? r_buf[r_idx] : '0;
  assign bus.flit_x_dest   = r_x_dest;
  assign bus.flit_y_dest   = r_y_dest;
  assign bus.drop_err      = r_drop_err;

endmodule
